// File: rtl/sp_frame_buffer.sv
// Double-banked 16-sample frame buffer that regroups a frame into four
// strided groups {x[g+12], x[g+8], x[g+4], x[g]} for a radix-4 butterfly stage.
module sp_frame_buffer #(
    parameter int SAMPLE_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*SAMPLE_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*SAMPLE_W-1:0] out_data,
    output logic [2:0]            rotation,
    output logic                  out_last
);

    localparam int CW = 2 * SAMPLE_W;

    logic [CW-1:0] mem_q [2][16];

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [3:0] wr_cnt_q, wr_cnt_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] grp_q, grp_d;

    logic wr_fire;
    logic rd_fire;

    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;

    // A completing write and a final read always target different banks,
    // so both flag updates can be applied to full_d independently.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        grp_d     = grp_q;
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_fire) begin
            grp_d = grp_q + 2'd1;
            if (grp_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= 4'd0;
            rd_bank_q <= 1'b0;
            grp_q     <= 2'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            grp_q     <= grp_d;
        end
    end

    // Sample storage is not reset; the full flags alone decide what is live.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= in_data;
        end
    end

    always_comb begin
        out_data = '0;
        rotation = 3'd0;
        out_last = 1'b0;
        if (out_valid) begin
            for (int i = 0; i < 4; i++) begin
                out_data[i*CW +: CW] = mem_q[rd_bank_q][{2'(i), grp_q}];
            end
            rotation = {1'b0, grp_q};
            out_last = (grp_q == 2'd3);
        end
    end

endmodule
